// File: rtl/inst_fill_unit_pkg.sv
// Shared CPU definitions: instruction-fill FSM encoding, fill geometry and
// instruction-cache geometry constants.
package inst_fill_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDone  = 2'd2
  } fill_state_e;

  localparam int unsigned WordBytes  = 4;
  localparam int unsigned MemLatency = 1;

  localparam int unsigned ICacheLines  = 256;
  localparam int unsigned ICacheIndexW = $clog2(ICacheLines);
  localparam int unsigned ICacheTagW   = 32 - ICacheIndexW - $clog2(WordBytes);

endpackage

// File: rtl/inst_fill_unit.sv
// Instruction-cache refill: fetches one aligned word byte-by-byte from RAM and
// presents it to the cache update port as a single-cycle strobe.
module inst_fill_unit
  import inst_fill_unit_pkg::*;
#(
  parameter int unsigned WORD_BYTES  = WordBytes,
  parameter int unsigned MEM_LATENCY = MemLatency
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        upd_valid,
  output logic [31:0] upd_addr,
  output logic [31:0] upd_data
);

  localparam logic [2:0] WordCnt = 3'(WORD_BYTES);
  localparam logic [2:0] Lat     = 3'(MEM_LATENCY);

  fill_state_e state_q, state_d;
  logic [2:0]  iss_q, iss_d;
  logic [2:0]  cap_q, cap_d;
  logic [31:0] base_q, base_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  iss_off;
  logic        unused_addr_lsb;

  // Word fills are always aligned; the low address bits carry no information.
  assign unused_addr_lsb = ^req_addr[1:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      iss_q   <= 3'd0;
      cap_q   <= 3'd0;
      base_q  <= 32'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    cap_d   = cap_q;
    base_d  = base_q;
    data_d  = data_q;
    if (rdy_in) begin
      if (flush) begin
        state_d = StIdle;
        iss_d   = 3'd0;
        cap_d   = 3'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (req_valid) begin
              state_d = StFetch;
              base_d  = {req_addr[31:2], 2'b00};
              iss_d   = 3'd0;
              cap_d   = 3'd0;
            end
          end
          StFetch: begin
            if (iss_q < WordCnt) iss_d = iss_q + 3'd1;
            // A byte is on mem_din once its address has been out for MEM_LATENCY cycles.
            if ((cap_q + Lat) <= iss_q) begin
              for (int k = 0; k < int'(WORD_BYTES); k++) begin
                if (cap_q == 3'(k)) data_d[8*k +: 8] = mem_din;
              end
              cap_d = cap_q + 3'd1;
              if (cap_q == WordCnt - 3'd1) state_d = StDone;
            end
          end
          StDone: begin
            state_d = StIdle;
            iss_d   = 3'd0;
            cap_d   = 3'd0;
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q == StFetch) begin
      // A stall abandons the burst; it is reissued from byte 0 when rdy_in returns.
      iss_d = 3'd0;
      cap_d = 3'd0;
    end
  end

  assign iss_off   = (iss_q < WordCnt) ? iss_q : (WordCnt - 3'd1);
  assign mem_a     = base_q + {29'd0, iss_off};
  assign mem_rd    = rdy_in && (state_q == StFetch) && (iss_q < WordCnt);
  assign mem_wr    = 1'b0;
  assign req_ready = (state_q == StIdle);
  assign upd_valid = rdy_in && !flush && (state_q == StDone);
  assign upd_addr  = base_q;
  assign upd_data  = data_q;

endmodule
